// File: rtl/mux_display_driver_pkg.sv
// Shared definitions for the multiplexed 15-segment display driver:
// segment bus width, blank pattern and a width helper for counters.
package mux_display_driver_pkg;

   localparam int SEG_W = 15;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_BLANK = 15'h0000;

   // Bits needed to hold 0..value-1, never less than one so 1-entry counters stay legal.
   function automatic int clog2_min1(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      return width;
   endfunction

endpackage

// File: rtl/mux_display_driver_decoder.sv
// Library decoder: 4-bit code to 15-segment pattern.
// Bits: 0..5 = a..f, 6 = g1, 7 = g2, 8..13 = h..m, 14 = dp.
module mux_display_driver_decoder
   import mux_display_driver_pkg::*;
(
   input  logic [3:0] i_code,
   output seg_t       o_segments
);

   // Code to pattern lookup; B and D use the centre vertical bars (i, l).
   always_comb begin
      case (i_code)
         4'h0:    o_segments = 15'h003F;
         4'h1:    o_segments = 15'h0006;
         4'h2:    o_segments = 15'h00DB;
         4'h3:    o_segments = 15'h008F;
         4'h4:    o_segments = 15'h00E6;
         4'h5:    o_segments = 15'h00ED;
         4'h6:    o_segments = 15'h00FD;
         4'h7:    o_segments = 15'h0007;
         4'h8:    o_segments = 15'h00FF;
         4'h9:    o_segments = 15'h00EF;
         4'hA:    o_segments = 15'h00F7;
         4'hB:    o_segments = 15'h128F;
         4'hC:    o_segments = 15'h0039;
         4'hD:    o_segments = 15'h120F;
         4'hE:    o_segments = 15'h0079;
         4'hF:    o_segments = 15'h0071;
         default: o_segments = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/mux_display_driver.sv
// Time-multiplexed driver for a row of 15-segment digits with dead-time,
// double-buffered code loading, leading-zero blanking and per-digit blink.
module mux_display_driver
   import mux_display_driver_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 1000,
   parameter int BLINK_FRAMES = 64
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [4*DIGITS-1:0]   codes_in,
   input  logic                  load,
   output logic                  pending,
   output logic                  load_ack,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [DIGITS-1:0]     digit_sel,
   output logic [SEG_W-1:0]      segments,
   output logic                  frame_tick
);

   localparam int IW = clog2_min1(DIGITS);
   localparam int PW = clog2_min1(PRESCALE);
   localparam int FW = clog2_min1(BLINK_FRAMES);

   localparam logic [PW-1:0]     PCNT_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [FW-1:0]     FCNT_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [DIGITS-1:0] SEL_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

   logic [PW-1:0]             r_pcnt;
   logic [IW-1:0]             r_idx;
   logic [FW-1:0]             r_fcnt;
   logic                      r_phase;
   logic [DIGITS-1:0][3:0]    r_active;
   logic [DIGITS-1:0][3:0]    r_shadow;
   logic                      r_pending;
   logic                      r_load_ack;
   logic [DIGITS-1:0]         r_digit_sel;
   seg_t                      r_segments;
   logic                      r_frame_tick;

   logic                      w_slot_end;
   logic                      w_frame_end;
   logic [3:0]                w_code;
   seg_t                      w_dec_seg;
   logic [DIGITS-1:0]         w_lz_blank;
   logic                      w_blanked;

   assign w_slot_end  = enable & (r_pcnt == PCNT_LAST);
   assign w_frame_end = w_slot_end & (r_idx == IDX_LAST);
   assign w_code      = r_active[r_idx];

   mux_display_driver_decoder u_display_decoder (
      .i_code     (w_code),
      .o_segments (w_dec_seg)
   );

   // A digit is a leading zero when it and every more-significant digit are zero; digit 0 always shows.
   always_comb begin : lz_scan
      logic w_zero_run;
      w_zero_run = 1'b1;
      w_lz_blank = {DIGITS{1'b0}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_run    = w_zero_run & (r_active[i] == 4'h0);
         w_lz_blank[i] = w_zero_run & (i != 0);
      end
   end

   assign w_blanked = (blank_lz & w_lz_blank[r_idx]) | (r_phase & blink_mask[r_idx]);

   // Slot prescaler, digit index and blink frame counter; all hold while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt  <= {PW{1'b0}};
         r_idx   <= {IW{1'b0}};
         r_fcnt  <= {FW{1'b0}};
         r_phase <= 1'b0;
      end else if (enable) begin
         if (w_slot_end) begin
            r_pcnt <= {PW{1'b0}};
            r_idx  <= (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
         end else begin
            r_pcnt <= r_pcnt + PW'(1);
         end
         if (w_frame_end) begin
            if (r_fcnt == FCNT_LAST) begin
               r_fcnt  <= {FW{1'b0}};
               r_phase <= ~r_phase;
            end else begin
               r_fcnt <= r_fcnt + FW'(1);
            end
         end
      end
   end

   // Shadow/active double buffer: commits only at the frame boundary so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow   <= {(4*DIGITS){1'b0}};
         r_active   <= {(4*DIGITS){1'b0}};
         r_pending  <= 1'b0;
         r_load_ack <= 1'b0;
      end else begin
         if (load) begin
            r_shadow <= codes_in;
         end
         if (w_frame_end) begin
            if (load) begin
               r_active <= codes_in;
            end else if (r_pending) begin
               r_active <= r_shadow;
            end
            r_pending  <= 1'b0;
            r_load_ack <= load | r_pending;
         end else begin
            r_load_ack <= 1'b0;
            if (load) begin
               r_pending <= 1'b1;
            end
         end
      end
   end

   // Pin registers: slot cycle 0 is dead-time so adjacent digits never overlap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digit_sel  <= {DIGITS{1'b0}};
         r_segments   <= SEG_BLANK;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame_end;
         if (!enable || (r_pcnt == {PW{1'b0}})) begin
            r_digit_sel <= {DIGITS{1'b0}};
            r_segments  <= SEG_BLANK;
         end else begin
            r_digit_sel <= SEL_ONE << r_idx;
            r_segments  <= w_blanked ? SEG_BLANK : w_dec_seg;
         end
      end
   end

   assign pending    = r_pending;
   assign load_ack   = r_load_ack;
   assign digit_sel  = r_digit_sel;
   assign segments   = r_segments;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_mux_display_driver.sv
// Directed self-checking bench for mux_display_driver (4 digits, 4-cycle slots, 2-frame blink).
module tb_mux_display_driver;

   localparam int DIGITS       = 4;
   localparam int PRESCALE     = 4;
   localparam int BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] codes_in;
   logic        load;
   logic        pending;
   logic        load_ack;
   logic        blank_lz;
   logic [3:0]  blink_mask;
   logic [3:0]  digit_sel;
   logic [14:0] segments;
   logic        frame_tick;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux_display_driver #(
      .DIGITS       (DIGITS),
      .PRESCALE     (PRESCALE),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .codes_in   (codes_in),
      .load       (load),
      .pending    (pending),
      .load_ack   (load_ack),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .digit_sel  (digit_sel),
      .segments   (segments),
      .frame_tick (frame_tick)
   );

   // Hand-written library decoder table.
   function automatic logic [14:0] seg_of(input logic [3:0] c);
      case (c)
         4'h0:    return 15'h003F;
         4'h1:    return 15'h0006;
         4'h2:    return 15'h00DB;
         4'h3:    return 15'h008F;
         4'h4:    return 15'h00E6;
         4'h5:    return 15'h00ED;
         4'h6:    return 15'h00FD;
         4'h7:    return 15'h0007;
         4'h8:    return 15'h00FF;
         4'h9:    return 15'h00EF;
         4'hA:    return 15'h00F7;
         4'hB:    return 15'h128F;
         4'hC:    return 15'h0039;
         4'hD:    return 15'h120F;
         4'hE:    return 15'h0079;
         default: return 15'h0071;
      endcase
   endfunction

   // j = 1..16 counts negedges after a frame_tick; j=1 shows the dead cycle of slot 0.
   function automatic logic [3:0] exp_sel(input int j);
      int p;
      int d;
      p = (j - 1) % 4;
      d = (j - 1) / 4;
      if (p == 0) return 4'b0000;
      return 4'b0001 << d;
   endfunction

   function automatic logic [14:0] exp_seg(input int j, input logic [3:0][14:0] s);
      int p;
      int d;
      p = (j - 1) % 4;
      d = (j - 1) / 4;
      if (p == 0) return 15'h0000;
      return s[d];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n      = 1'b0;
      enable     = 1'b0;
      load       = 1'b0;
      codes_in   = 16'h0000;
      blank_lz   = 1'b0;
      blink_mask = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b1;
      enable     = 1'b0;
      load       = 1'b0;
      codes_in   = 16'h0000;
      blank_lz   = 1'b0;
      blink_mask = 4'b0000;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (digit_sel !== 4'b0000 || segments !== 15'h0000 || pending !== 1'b0 ||
          load_ack !== 1'b0 || frame_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: sel=%b seg=%h pend=%b ack=%b tick=%b, want all 0",
                  digit_sel, segments, pending, load_ack, frame_tick);
      end
   endtask

   task automatic test_load_commit();
      logic [3:0][14:0] s;
      int got;
      do_reset();
      codes_in = 16'h4321;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n_tests++;
      if (pending !== 1'b1) begin
         n_fail++;
         $display("FAIL load_pending: pending=%b, want 1", pending);
      end
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) got = 1;
      end
      n_tests++;
      if (got != 1 || load_ack !== 1'b1 || pending !== 1'b0) begin
         n_fail++;
         $display("FAIL load_commit: tick_seen=%0d ack=%b pending=%b, want 1 1 0", got, load_ack, pending);
      end
      s = {seg_of(4'h4), seg_of(4'h3), seg_of(4'h2), seg_of(4'h1)};
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         n_tests++;
         if (digit_sel !== exp_sel(j) || segments !== exp_seg(j, s) || frame_tick !== (j == 16) ||
             load_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_4321 j=%0d: sel=%b seg=%h tick=%b ack=%b, want sel=%b seg=%h tick=%b ack=0",
                     j, digit_sel, segments, frame_tick, load_ack, exp_sel(j), exp_seg(j, s), (j == 16));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0][14:0] s;
      int acks;
      acks = 0;
      s = {seg_of(4'h4), seg_of(4'h3), seg_of(4'h2), seg_of(4'h1)};
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (load_ack === 1'b1) acks++;
         n_tests++;
         if (digit_sel !== exp_sel(j) || segments !== exp_seg(j, s)) begin
            n_fail++;
            $display("FAIL b2b_hold j=%0d: sel=%b seg=%h, want sel=%b seg=%h",
                     j, digit_sel, segments, exp_sel(j), exp_seg(j, s));
         end
         if (j == 2)  begin codes_in = 16'h0000; load = 1'b1; end
         if (j == 3)  load = 1'b0;
         if (j == 6)  begin codes_in = 16'h0305; load = 1'b1; end
         if (j == 7)  load = 1'b0;
      end
      n_tests++;
      if (acks != 1 || load_ack !== 1'b1 || pending !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ack: acks=%0d ack_at_F=%b pending=%b, want 1 1 0", acks, load_ack, pending);
      end
      acks = 0;
      s = {seg_of(4'h0), seg_of(4'h3), seg_of(4'h0), seg_of(4'h5)};
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (load_ack === 1'b1) acks++;
         n_tests++;
         if (digit_sel !== exp_sel(j) || segments !== exp_seg(j, s)) begin
            n_fail++;
            $display("FAIL b2b_0305 j=%0d: sel=%b seg=%h, want sel=%b seg=%h",
                     j, digit_sel, segments, exp_sel(j), exp_seg(j, s));
         end
      end
      n_tests++;
      if (acks != 0) begin
         n_fail++;
         $display("FAIL b2b_extra_ack: acks=%0d, want 0", acks);
      end
   endtask

   task automatic test_blank_lz();
      logic [3:0][14:0] s;
      logic [15:0] vals [2];
      int got;
      vals[0] = 16'h0070;
      vals[1] = 16'h0000;
      blank_lz = 1'b1;
      for (int v = 0; v < 2; v++) begin
         codes_in = vals[v];
         load     = 1'b1;
         @(negedge clk);
         load = 1'b0;
         got  = 0;
         for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) got = 1;
         end
         n_tests++;
         if (got != 1 || load_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL lz_commit v=%0d: tick_seen=%0d ack=%b, want 1 1", v, got, load_ack);
         end
         if (v == 0) s = {15'h0000, 15'h0000, seg_of(4'h7), seg_of(4'h0)};
         else        s = {15'h0000, 15'h0000, 15'h0000, seg_of(4'h0)};
         for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            n_tests++;
            if (digit_sel !== exp_sel(j) || segments !== exp_seg(j, s)) begin
               n_fail++;
               $display("FAIL lz v=%0d j=%0d: sel=%b seg=%h, want sel=%b seg=%h",
                        v, j, digit_sel, segments, exp_sel(j), exp_seg(j, s));
            end
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_blink();
      logic [3:0][14:0] s;
      do_reset();
      codes_in   = 16'h4321;
      load       = 1'b1;
      blink_mask = 4'b0010;
      for (int f = 0; f < 6; f++) begin
         if (f == 0) s = {seg_of(4'h0), seg_of(4'h0), seg_of(4'h0), seg_of(4'h0)};
         else        s = {seg_of(4'h4), seg_of(4'h3), seg_of(4'h2), seg_of(4'h1)};
         if (f == 2 || f == 3) s[1] = 15'h0000;
         for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (f == 0 && j == 1) load = 1'b0;
            n_tests++;
            if (digit_sel !== exp_sel(j) || segments !== exp_seg(j, s) || frame_tick !== (j == 16)) begin
               n_fail++;
               $display("FAIL blink f=%0d j=%0d: sel=%b seg=%h tick=%b, want sel=%b seg=%h tick=%b",
                        f, j, digit_sel, segments, frame_tick, exp_sel(j), exp_seg(j, s), (j == 16));
            end
         end
      end
      blink_mask = 4'b0000;
   endtask

   task automatic test_load_at_f_and_enable();
      logic [3:0][14:0] s;
      logic [3:0]  e_sel [4];
      logic [14:0] e_seg [4];
      do_reset();
      repeat (15) @(negedge clk);
      codes_in = 16'hABCD;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n_tests++;
      if (load_ack !== 1'b1 || frame_tick !== 1'b1 || pending !== 1'b0) begin
         n_fail++;
         $display("FAIL load_at_F: ack=%b tick=%b pending=%b, want 1 1 0", load_ack, frame_tick, pending);
      end
      s = {seg_of(4'hA), seg_of(4'hB), seg_of(4'hC), seg_of(4'hD)};
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         n_tests++;
         if (digit_sel !== exp_sel(j) || segments !== exp_seg(j, s)) begin
            n_fail++;
            $display("FAIL scan_ABCD j=%0d: sel=%b seg=%h, want sel=%b seg=%h",
                     j, digit_sel, segments, exp_sel(j), exp_seg(j, s));
         end
      end
      repeat (6) @(negedge clk);
      n_tests++;
      if (digit_sel !== 4'b0010 || segments !== seg_of(4'hC)) begin
         n_fail++;
         $display("FAIL pre_disable: sel=%b seg=%h, want sel=0010 seg=%h", digit_sel, segments, seg_of(4'hC));
      end
      enable = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if (digit_sel !== 4'b0000 || segments !== 15'h0000 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled c=%0d: sel=%b seg=%h tick=%b, want 0 0 0", c, digit_sel, segments, frame_tick);
         end
      end
      enable = 1'b1;
      e_sel[0] = 4'b0010; e_seg[0] = seg_of(4'hC);
      e_sel[1] = 4'b0010; e_seg[1] = seg_of(4'hC);
      e_sel[2] = 4'b0000; e_seg[2] = 15'h0000;
      e_sel[3] = 4'b0100; e_seg[3] = seg_of(4'hB);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_tests++;
         if (digit_sel !== e_sel[c] || segments !== e_seg[c]) begin
            n_fail++;
            $display("FAIL resume c=%0d: sel=%b seg=%h, want sel=%b seg=%h", c, digit_sel, segments, e_sel[c], e_seg[c]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int acks;
      int ticks;
      do_reset();
      codes_in = 16'h1111;
      load     = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (5) @(negedge clk);
      n_tests++;
      if (pending !== 1'b1 || digit_sel !== 4'b0010 || segments !== seg_of(4'h0)) begin
         n_fail++;
         $display("FAIL pre_reset: pending=%b sel=%b seg=%h, want 1 0010 %h", pending, digit_sel, segments, seg_of(4'h0));
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (digit_sel !== 4'b0000 || segments !== 15'h0000 || pending !== 1'b0 ||
          load_ack !== 1'b0 || frame_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: sel=%b seg=%h pend=%b ack=%b tick=%b, want all 0",
                  digit_sel, segments, pending, load_ack, frame_tick);
      end
      @(negedge clk);
      rst_n = 1'b1;
      acks  = 0;
      ticks = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (load_ack === 1'b1) acks++;
         if (frame_tick === 1'b1) ticks++;
      end
      n_tests++;
      if (acks != 0 || ticks != 2 || pending !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: acks=%0d ticks=%0d pending=%b, want 0 2 0", acks, ticks, pending);
      end
   endtask

   initial begin
      test_reset();
      test_load_commit();
      test_back_to_back();
      test_blank_lz();
      test_blink();
      test_load_at_f_and_enable();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
